// File: rtl/voice_mix_if.sv
// Frame/config bus between the voice bank, the gain configuration port and the mix sequencer.
// The master side drives frames and gain writes; the slave side returns the mixed sample and status.
`timescale 1ns/1ps
interface voice_mix_if #(
  parameter int NUM_VOICES = 6,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_W     = 8
);
  localparam int ADDR_W = $clog2(NUM_VOICES);

  logic [NUM_VOICES*SAMPLE_W-1:0] voice_smp;
  logic                           sample_ready;
  logic                           cfg_we;
  logic [ADDR_W-1:0]              cfg_addr;
  logic [GAIN_W-1:0]              cfg_gain;
  logic signed [SAMPLE_W-1:0]     mix_out;
  logic                           mix_valid;
  logic                           clip;
  logic                           overrun;
  logic                           busy;

  modport master (
    output voice_smp, sample_ready, cfg_we, cfg_addr, cfg_gain,
    input  mix_out, mix_valid, clip, overrun, busy
  );

  modport slave (
    input  voice_smp, sample_ready, cfg_we, cfg_addr, cfg_gain,
    output mix_out, mix_valid, clip, overrun, busy
  );
endinterface

// File: rtl/voice_mix_sequencer.sv
// Per-frame voice mixer: snapshots all voices and gains on sample_ready, then time-shares one
// signed multiplier across the voices, accumulates, shifts and saturates to a mono sample.
`timescale 1ns/1ps
module voice_mix_sequencer #(
  parameter int NUM_VOICES = 6,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_W     = 8,
  parameter int SHIFT      = 7,
  parameter int GAIN_RESET = 16
) (
  input  logic         clk37,
  input  logic         rst_n,
  voice_mix_if.slave   bus
);

  localparam int ADDR_W = $clog2(NUM_VOICES);
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + ADDR_W;

  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic signed [SAMPLE_W-1:0] snap_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] snap_d [NUM_VOICES];
  logic [GAIN_W-1:0]          gsnap_q [NUM_VOICES];
  logic [GAIN_W-1:0]          gsnap_d [NUM_VOICES];
  logic [GAIN_W-1:0]          gain_q [NUM_VOICES];
  logic [GAIN_W-1:0]          gain_d [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] mix_out_q, mix_out_d;
  logic                       mix_valid_q, mix_valid_d;
  logic                       clip_q, clip_d;

  logic signed [ACC_W-1:0]    acc_shr;
  logic                       sat_hi;
  logic                       sat_lo;
  logic signed [SAMPLE_W-1:0] sat_val;

  // Arithmetic shift floors toward -inf; the guard bits keep the compare exact.
  assign acc_shr = acc_q >>> SHIFT;
  assign sat_hi  = (acc_shr > SAT_MAX);
  assign sat_lo  = (acc_shr < SAT_MIN);

  always_comb begin
    if (sat_hi) begin
      sat_val = SAT_MAX[SAMPLE_W-1:0];
    end else if (sat_lo) begin
      sat_val = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_val = acc_shr[SAMPLE_W-1:0];
    end
  end

  // Gain table accepts writes in every state; out-of-range addresses are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gain_d = gain_q;
    if (bus.cfg_we && (bus.cfg_addr <= LAST_IDX)) begin
      gain_d[bus.cfg_addr] = bus.cfg_gain;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    snap_d      = snap_q;
    gsnap_d     = gsnap_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    clip_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.sample_ready) begin
          // The snapshot takes gain_q, so a write on this same edge lands in the next frame.
          for (int i = 0; i < NUM_VOICES; i++) begin
            snap_d[i] = bus.voice_smp[i*SAMPLE_W +: SAMPLE_W];
          end
          gsnap_d = gain_q;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end

      ST_MAC: begin
        prod_d = PROD_W'(snap_q[idx_q]) * PROD_W'($signed({1'b0, gsnap_q[idx_q]}));
        if (idx_q != '0) begin
          acc_d = acc_q + ACC_W'(prod_q);
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end

      ST_DRAIN: begin
        acc_d   = acc_q + ACC_W'(prod_q);
        state_d = ST_OUT;
      end

      ST_OUT: begin
        mix_out_d   = sat_val;
        mix_valid_d = 1'b1;
        clip_d      = sat_hi | sat_lo;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the gain table and frame snapshots are reset explicitly because the mix after reset
  // must come from known gains; they are plain flops, not a RAM macro.
  always_ff @(posedge clk37 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap_q[i]  <= '0;
        gsnap_q[i] <= '0;
        gain_q[i]  <= GAIN_W'(GAIN_RESET);
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      snap_q      <= snap_d;
      gsnap_q     <= gsnap_d;
      gain_q      <= gain_d;
    end
  end

  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.clip      = clip_q;
  assign bus.busy      = (state_q != ST_IDLE);
  // A strobe arriving mid-frame is dropped; flag it in the cycle it arrives.
  assign bus.overrun   = bus.sample_ready && (state_q != ST_IDLE);

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Directed and table-driven bench for voice_mix_sequencer: latency, saturation, overrun,
// gain-write timing, mid-frame reset and a back-to-back frame run against a reference model.
`timescale 1ns/1ps
module tb_voice_mix_sequencer;

  typedef struct {
    string             name;
    logic [5:0][15:0]  v;
    logic [5:0][7:0]   g;
    logic signed [15:0] m;
    logic              c;
  } vec_t;

  typedef struct {
    logic signed [15:0] m;
    logic               c;
  } exp_t;

  logic clk37;
  logic rst_n;
  int   checks;
  int   errors;

  voice_mix_if #(.NUM_VOICES(6), .SAMPLE_W(16), .GAIN_W(8)) bus ();

  voice_mix_sequencer dut (
    .clk37 (clk37),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk37 = 1'b0;
  always #13 clk37 = ~clk37;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk37);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [7:0] gain);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_gain = gain;
    next_cycle();
    bus.cfg_we   = 1'b0;
  endtask

  // Pulses sample_ready (with any cfg fields already set) and waits for mix_valid.
  task automatic run_frame(input logic [5:0][15:0] v, output logic signed [15:0] m,
                           output logic c, output int lat);
    lat = -1;
    m   = '0;
    c   = 1'b0;
    bus.voice_smp    = v;
    bus.sample_ready = 1'b1;
    next_cycle();
    bus.sample_ready = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.voice_smp    = {3{32'hDEAD_BEEF}};
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk37);
      if (bus.mix_valid) begin
        lat = k;
        m   = bus.mix_out;
        c   = bus.clip;
        next_cycle();
        break;
      end
      next_cycle();
    end
  endtask

  function automatic exp_t model(input logic [5:0][15:0] v, input logic [7:0] g[6]);
    longint acc;
    longint s;
    exp_t   r;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      acc += longint'($signed(v[i])) * longint'(g[i]);
    end
    s = acc >>> 7;
    if (s > 32767) begin
      r.m = 16'sd32767;
      r.c = 1'b1;
    end else if (s < -32768) begin
      r.m = -16'sd32768;
      r.c = 1'b1;
    end else begin
      r.m = s[15:0];
      r.c = 1'b0;
    end
    return r;
  endfunction

  vec_t               vecs[9];
  exp_t               q[$];
  exp_t               e;
  logic [7:0]         gm[6];
  logic signed [15:0] m;
  logic               c;
  int                 lat;
  int                 ov_cnt, ov_at, mv_cnt, mv_at;
  logic signed [15:0] mv_val;
  logic [2:0]         wa;
  logic [7:0]         wg;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{name:"neg_full_scale", v:'0, g:'0, m:-16'sd32768, c:1'b0};
    vecs[0].v[0] = 16'h8000; vecs[0].g[0] = 8'd128;
    vecs[1] = '{name:"pos_clip", v:'0, g:'0, m:16'sd32767, c:1'b1};
    vecs[1].v[0] = 16'd30000; vecs[1].v[1] = 16'd30000;
    vecs[1].g[0] = 8'd128;    vecs[1].g[1] = 8'd128;
    vecs[2] = '{name:"neg_clip", v:{6{-16'sd20000}}, g:{6{8'd128}}, m:-16'sd32768, c:1'b1};
    vecs[3] = '{name:"floor_shift", v:{6{16'hFFFF}}, g:{6{8'd255}}, m:-16'sd12, c:1'b0};
    vecs[4] = '{name:"mixed_signs",
                v:{-16'sd600, 16'sd500, -16'sd400, 16'sd300, -16'sd200, 16'sd100},
                g:{8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128}, m:16'sd37, c:1'b0};
    vecs[5] = '{name:"max_magnitude", v:{6{16'h7FFF}}, g:{6{8'd255}}, m:16'sd32767, c:1'b1};
    vecs[6] = '{name:"last_voice_only", v:{6{16'd5000}}, g:'0, m:16'sd1234, c:1'b0};
    vecs[6].v[5] = 16'd1234; vecs[6].g[5] = 8'd128;
    vecs[7] = '{name:"max_no_clip", v:'0, g:'0, m:16'sd32767, c:1'b0};
    vecs[7].v[0] = 16'h7FFF; vecs[7].g[0] = 8'd128;
    vecs[8] = '{name:"max_plus_one", v:'0, g:'0, m:16'sd32767, c:1'b1};
    vecs[8].v[0] = 16'h7FFF; vecs[8].v[1] = 16'd1;
    vecs[8].g[0] = 8'd128;   vecs[8].g[1] = 8'd128;

    rst_n            = 1'b0;
    bus.voice_smp    = '0;
    bus.sample_ready = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_gain     = '0;
    repeat (3) @(posedge clk37);
    #1 rst_n = 1'b1;

    @(negedge clk37);
    check("reset_mix_out", bus.mix_out, 0);
    check("reset_mix_valid", bus.mix_valid, 0);
    check("reset_clip", bus.clip, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_overrun", bus.overrun, 0);
    next_cycle();

    // Default gains after reset
    run_frame({6{16'd1000}}, m, c, lat);
    check("t1_latency", lat, 9);
    check("t1_mix", m, 750);
    check("t1_clip", c, 0);

    // Second strobe 4 cycles in is dropped and flagged; changed voices must not leak in
    ov_cnt = 0; ov_at = -1; mv_cnt = 0; mv_at = -1; mv_val = '0;
    for (int k = 0; k < 14; k++) begin
      bus.sample_ready = (k == 0) || (k == 4);
      bus.voice_smp    = (k == 0) ? {6{16'd1000}} : {6{16'd5000}};
      @(negedge clk37);
      if (bus.overrun) begin ov_cnt++; ov_at = k; end
      if (bus.mix_valid) begin mv_cnt++; mv_at = k; mv_val = bus.mix_out; end
      if (k == 4) check("t3_busy_mid_frame", bus.busy, 1);
      next_cycle();
    end
    bus.sample_ready = 1'b0;
    check("t3_overrun_count", ov_cnt, 1);
    check("t3_overrun_cycle", ov_at, 4);
    check("t3_valid_count", mv_cnt, 1);
    check("t3_valid_cycle", mv_at, 9);
    check("t3_mix", mv_val, 750);

    // Gain write on the capture edge applies only to the following frame
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_gain = 8'd0;
    run_frame({6{16'd1000}}, m, c, lat);
    check("t4_same_edge_mix", m, 750);
    run_frame({6{16'd1000}}, m, c, lat);
    check("t4_next_frame_mix", m, 625);
    cfg_write(3'd7, 8'd0);
    run_frame({6{16'd1000}}, m, c, lat);
    check("t4_addr7_ignored", m, 625);

    // Reset in the middle of MAC abandons the frame
    bus.voice_smp    = {6{16'd1000}};
    bus.sample_ready = 1'b1;
    next_cycle();
    bus.sample_ready = 1'b0;
    next_cycle();
    next_cycle();
    check("t5_busy_before_reset", bus.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_reset_mix_out", bus.mix_out, 0);
    check("t5_reset_busy", bus.busy, 0);
    check("t5_reset_valid", bus.mix_valid, 0);
    @(posedge clk37);
    @(posedge clk37);
    #1 rst_n = 1'b1;
    mv_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk37);
      if (bus.mix_valid) mv_cnt++;
      next_cycle();
    end
    check("t5_no_valid_after_reset", mv_cnt, 0);
    run_frame({6{16'd1000}}, m, c, lat);
    check("t5_gains_restored", m, 750);
    check("t5_latency", lat, 9);

    // Table-driven vectors
    foreach (vecs[n]) begin
      for (int i = 0; i < 6; i++) cfg_write(3'(i), vecs[n].g[i]);
      run_frame(vecs[n].v, m, c, lat);
      check({vecs[n].name, "_mix"}, m, vecs[n].m);
      check({vecs[n].name, "_clip"}, c, vecs[n].c);
      check({vecs[n].name, "_latency"}, lat, 9);
    end

    // Back-to-back random frames at the minimum period against the model
    for (int i = 0; i < 6; i++) begin
      gm[i] = 8'($urandom_range(0, 255));
      cfg_write(3'(i), gm[i]);
    end
    ov_cnt = 0;
    mv_cnt = 0;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 9; k++) begin
        bus.voice_smp    = {$urandom, $urandom, $urandom};
        bus.sample_ready = (k == 0);
        bus.cfg_we       = 1'b0;
        if (k == 0 || k == 3) begin
          wa = 3'($urandom_range(0, 7));
          wg = 8'($urandom_range(0, 255));
          bus.cfg_we   = 1'b1;
          bus.cfg_addr = wa;
          bus.cfg_gain = wg;
        end
        if (k == 0) q.push_back(model(bus.voice_smp, gm));
        if (bus.cfg_we && wa < 3'd6) gm[wa] = wg;
        @(negedge clk37);
        if (bus.overrun) ov_cnt++;
        if (bus.mix_valid) begin
          mv_cnt++;
          if (q.size() == 0) begin
            check("rand_unexpected_valid", 1, 0);
          end else begin
            e = q.pop_front();
            check("rand_mix", bus.mix_out, e.m);
            check("rand_clip", bus.clip, e.c);
          end
        end
        next_cycle();
      end
    end
    bus.sample_ready = 1'b0;
    bus.cfg_we       = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk37);
      if (bus.mix_valid) begin
        mv_cnt++;
        if (q.size() == 0) begin
          check("rand_unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("rand_mix", bus.mix_out, e.m);
          check("rand_clip", bus.clip, e.c);
        end
      end
      next_cycle();
    end
    check("rand_overrun_count", ov_cnt, 0);
    check("rand_valid_count", mv_cnt, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
